// File: rtl/exp_envelope_pkg.sv
// exp_envelope_pkg: shared types, width helpers and decay-table generator for exp_envelope_mc
package exp_envelope_pkg;

    typedef enum logic [1:0] {IDLE, DECAY, DONE} state_t;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // coef[0] is just below unity, each following entry is the previous one scaled by num/256
    function automatic int exp_coef(input int k, input int coef_w, input int num);
        longint c;
        c = (longint'(1) << coef_w) - 1;
        for (int i = 0; i < k; i++)
            c = (c * num) / 256;
        return int'(c);
    endfunction

endpackage

// File: rtl/exp_coef_rom.sv
// exp_coef_rom: decay coefficient table with one-cycle registered read
module exp_coef_rom import exp_envelope_pkg::*; #(
    parameter int COEF_W = 10,
    parameter int STEPS = 64,
    parameter int DECAY_NUM = 248,
    localparam int IDX_W = idx_width(STEPS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [IDX_W-1:0]  addr,
    output logic [COEF_W-1:0] coef
);

    logic [COEF_W-1:0] rom [STEPS];

    for (genvar k = 0; k < STEPS; k++) begin : g_rom
        assign rom[k] = COEF_W'(exp_coef(k, COEF_W, DECAY_NUM));
    end

    always_ff @(posedge clk)
        if (en) coef <= rom[addr];

endmodule

// File: rtl/exp_envelope_mc.sv
// exp_envelope_mc: per-channel note-triggered exponential decay applied to a
// channel-tagged sample stream, two-stage pipeline with valid/ready backpressure
module exp_envelope_mc import exp_envelope_pkg::*; #(
    parameter int SAMPLE_W = 16,
    parameter int COEF_W = 10,
    parameter int CHANNELS = 4,
    parameter int STEPS = 64,
    parameter int DUR_W = 6,
    parameter int STEP_SHIFT = 4,
    parameter int DECAY_NUM = 248,
    localparam int CH_W = ch_width(CHANNELS),
    localparam int IDX_W = idx_width(STEPS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0]        note_start,
    input  logic [DUR_W-1:0]           duration,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH_W-1:0]            in_chan,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_chan,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic [CHANNELS-1:0]        active
);

    localparam int CNT_W = DUR_W + STEP_SHIFT;

    state_t             st   [CHANNELS];
    logic [IDX_W-1:0]   step [CHANNELS];
    logic [CNT_W-1:0]   cnt  [CHANNELS];
    logic [DUR_W-1:0]   dur  [CHANNELS];

    logic                       stall, acc, hit, live, v1, live1;
    logic [CHANNELS-1:0]        sel;
    logic [CH_W-1:0]            ch1;
    logic signed [SAMPLE_W-1:0] smp1;
    logic [IDX_W-1:0]           rom_addr;
    logic [COEF_W-1:0]          coef, coef_eff;
    logic signed [COEF_W+SAMPLE_W:0] prod;

    assign stall = out_valid && !out_ready;
    assign in_ready = !stall;
    assign acc = in_valid && in_ready;
    assign hit = int'(in_chan) < CHANNELS;
    // coefficient comes from the pre-update state; a same-cycle trigger forces step 0
    assign live = hit && (note_start[in_chan] || st[in_chan] == DECAY);
    assign rom_addr = (hit && !note_start[in_chan]) ? step[in_chan] : '0;
    assign coef_eff = live1 ? coef : '0;
    assign prod = $signed({1'b0, coef_eff}) * smp1;

    always_comb begin
        sel = '0;
        if (acc && hit) sel[in_chan] = 1'b1;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_act
        assign active[c] = st[c] == DECAY;
    end

    exp_coef_rom #(.COEF_W(COEF_W), .STEPS(STEPS), .DECAY_NUM(DECAY_NUM)) u_rom (
        .clk(clk),
        .en(!stall),
        .addr(rom_addr),
        .coef(coef)
    );

    // period-1 is the latched duration followed by STEP_SHIFT ones
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (reset) begin
                st[c] <= IDLE;
                step[c] <= '0;
                cnt[c] <= '0;
                dur[c] <= '0;
            end else if (note_start[c]) begin
                st[c] <= DECAY;
                step[c] <= '0;
                dur[c] <= duration;
                cnt[c] <= CNT_W'(sel[c]);
            end else if (sel[c] && st[c] == DECAY) begin
                if (cnt[c] == {dur[c], {STEP_SHIFT{1'b1}}}) begin
                    cnt[c] <= '0;
                    if (step[c] == IDX_W'(STEPS - 1)) st[c] <= DONE;
                    else step[c] <= step[c] + 1'b1;
                end else begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            live1 <= 1'b0;
            ch1 <= '0;
            smp1 <= '0;
            out_valid <= 1'b0;
            out_chan <= '0;
            out_sample <= '0;
        end else if (!stall) begin
            v1 <= acc;
            live1 <= live;
            ch1 <= in_chan;
            smp1 <= in_sample;
            out_valid <= v1;
            out_chan <= ch1;
            out_sample <= SAMPLE_W'(prod >>> COEF_W);
        end
    end

endmodule

// File: doc/exp_envelope_mc.md
Name: exp_envelope_mc

Overview:
- Multi-channel, parametrised exponential-decay envelope stage for the synth voice path.
- Sits between the voice oscillators and the mixer. It accepts a time-multiplexed stream of signed samples tagged with a channel number and scales each sample by that channel's current decay coefficient.
- Each channel runs its own note-triggered decay state machine whose step rate is set by a per-note duration.
- The output stream carries valid/ready backpressure.

Parameters:
- SAMPLE_W, 16, signed sample width in and out.
- COEF_W, 10, unsigned coefficient fraction width; unity is 2^COEF_W.
- CHANNELS, 4, number of independent envelopes; CH_W = max(1, clog2(CHANNELS)).
- STEPS, 64, decay table length; IDX_W = clog2(STEPS).
- DUR_W, 6, duration input width.
- STEP_SHIFT, 4, per-step period multiplier exponent.
- DECAY_NUM, 248, per-step decay ratio numerator over 256.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- note_start  in  CHANNELS  one-cycle trigger per channel
- duration  in  DUR_W  latched into every channel whose note_start bit is high
- in_valid  in  1  input sample valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_chan  in  CH_W  channel of input sample
- in_sample  in  SAMPLE_W  signed sample
- out_valid  out  1  output valid
- out_ready  in  1  downstream accept
- out_chan  out  CH_W  channel of output sample
- out_sample  out  SAMPLE_W  signed decayed sample
- active  out  CHANNELS  channel is in DECAY

Behaviour:
- Reset (clk edge with reset=1):
  - All channels go to IDLE; step index, sample counter and latched duration are cleared.
  - Pipeline is flushed and in-flight samples are discarded.
  - out_valid=0, out_chan=0, out_sample=0, active=0.
- Per-channel FSM:
  - IDLE -> DECAY on note_start[c].
  - DECAY -> DONE when the step is STEPS-1 and the counter wraps.
  - DONE -> DECAY on note_start[c].
  - DECAY -> DECAY on note_start[c] (retrigger).
  - Entering or re-entering DECAY sets step=0 and cnt=0, and latches the duration.
- Step timing:
  - period = (dur+1) << STEP_SHIFT accepted samples of that channel.
  - Each accepted sample for channel c in DECAY increments cnt.
  - When cnt == period-1: cnt <= 0, and step <= step+1 if step < STEPS-1, otherwise the FSM goes to DONE.
  - Samples for other channels never affect channel c.
- Coefficient:
  - Supplied by a registered ROM: coef[0] = 2^COEF_W-1, coef[k] = floor(coef[k-1]*DECAY_NUM/256).
  - A channel in IDLE or DONE uses coefficient 0 (silent output, but the sample still passes with out_valid).
- Arithmetic:
  - product = signed({1'b0,coef}) * signed(sample), width COEF_W+1+SAMPLE_W.
  - out_sample = product >>> COEF_W, i.e. floor toward minus infinity (not truncation toward zero), truncated to SAMPLE_W.
  - No saturation is needed because coef < unity.
- Pipeline:
  - Two stages: S1 registers the ROM read plus sample and channel; S2 registers the product and shift.
  - An accepted input at edge N is presented at edge N+2 when there is no stall.
- Coefficient selection point:
  - The coefficient is chosen from the channel state before this sample's counter update.
  - The counter update happens at acceptance.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - While stalled, all pipeline registers hold and out_* stay stable.
  - Bubbles propagate as invalid, so out_valid drops when no data is present.
- Simultaneous events:
  - note_start[c] with an accepted sample for c in the same cycle: the retrigger wins, the sample uses coef[0], and afterwards cnt=1.
  - note_start during a stall still updates the FSM immediately.
  - Multiple note_start bits in one cycle all latch the same duration.
- in_chan >= CHANNELS: the sample is accepted, output is 0 and no state is modified.

Decomposition:
- Package exp_envelope_pkg:
  - CH_W and IDX_W derivation helpers.
  - exp_coef(k) constant function for building the ROM contents.
  - Channel state enum {IDLE, DECAY, DONE}.
- One sub-module, exp_coef_rom: parametrised by COEF_W, STEPS and DECAY_NUM; synchronous read with 1-cycle latency; contents built from the package function.

Test Plan:
1. Reset then stream ch0 without a trigger; in_sample=1000 -> out_sample=0, out_valid 2 cycles after each accept, active=0.
2. Positive and negative samples:
   - Setup: note_start[0], duration=0 (period 16).
   - in_sample=1000 -> out_sample=999; in_sample=-1000 -> -1000 (floor check).
   - The 17th sample uses coef[1]=991: 1000 -> 967.
3. Channel independence:
   - Setup: trigger ch1 with duration=3 (period 64) and ch2 with duration=0; interleave samples.
   - Required: ch2 reaches step 1 after 16 of its own samples while ch1 is still at step 0.
4. Terminal step and DONE:
   - Setup: duration=0, feed 16*64 samples to ch0.
   - Required: active[0] falls on the last one, then out_sample=0 for input 32767; retrigger gives 32735.
5. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable, no sample lost or duplicated, order preserved.
6. Retrigger and mid-operation reset:
   - Retrigger ch0 at step 5 in the same cycle as a ch0 sample of 500 -> output 499.
   - Assert reset with 2 samples in flight -> out_valid=0 the next cycle, all active=0.
